pc_unit: RTL
============

// Module: pc_unit
// PURPOSE
//  Parametrised program-counter unit for the MIPS fetch stage. Successor to the plain PC register.
//  Holds the PC and selects the next PC by priority: exception, eret, return, call/jump, branch,
//  stall, sequential. Contains an EPC register and a small circular return-address stack (RAS).
//  Sits between the next-PC logic of decode/execute and the instruction memory address port.
// PARAMETERS
//  DATA_WIDTH    32            PC, target and EPC width
//  PC_STEP       4             sequential increment in bytes
//  RESET_VECTOR  32'h0000_0000 pc_out value on reset
//  EXC_VECTOR    32'h8000_0180 exception handler entry address
//  RAS_DEPTH     4             return-address stack entries (>=2, power of 2)
// PORTS
//  clk            in   1             rising-edge clock
//  rst            in   1             asynchronous, active-high reset
//  stall          in   1             hold PC; blocks all redirects except exception
//  branch_taken   in   1             take branch_target
//  branch_target  in   DATA_WIDTH    branch destination
//  jump           in   1             take jump_target (j/jr/jal)
//  call           in   1             with jump: push pc_out+PC_STEP onto RAS (jal)
//  ret            in   1             return (jr $ra): next PC = RAS top, or jump_target if RAS empty
//  jump_target    in   DATA_WIDTH    jump destination / return fallback
//  exception      in   1             trap: next PC = EXC_VECTOR, EPC <= pc_out
//  eret           in   1             return from exception: next PC = EPC
//  pc_out         out  DATA_WIDTH    current PC (registered)
//  pc_plus_step   out  DATA_WIDTH    pc_out + PC_STEP (combinational)
//  epc_out        out  DATA_WIDTH    saved exception PC (registered)
//  ras_count      out  $clog2(RAS_DEPTH+1)  valid RAS entries (registered)
//  redirect       out  1             combinational; next PC is non-sequential (flush IF/ID)
// BEHAVIOUR
//  - Reset (async, rst high): pc_out=RESET_VECTOR, epc_out=0, ras_count=0, RAS pointer=0.
//    RAS entry contents are don't-care. Reset mid-operation discards any pending redirect.
//  - pc_out updates on each rising clk edge. Every redirect takes effect on the next edge
//    (1-cycle latency). Next-PC priority:
//    1 exception          -> EXC_VECTOR; epc <= pc_out. Taken even when stall=1.
//    2 eret  (!stall)     -> epc_out
//    3 ret   (!stall)     -> RAS top if ras_count>0 (pop: count-1); else jump_target (count stays 0)
//    4 jump  (!stall)     -> jump_target; if call: push pc_plus_step
//    5 branch_taken(!stall) -> branch_target
//    6 stall              -> hold pc_out
//    7 otherwise          -> pc_plus_step
//  - redirect=1 when priority 1-5 is selected, else 0. It is 0 under stall without exception.
//  - Stack operations happen only when their option is the selected winner. A suppressed
//    call/ret does not change the RAS.
//  - RAS full (count=RAS_DEPTH) and push: the oldest entry is overwritten (circular pointer).
//    Count saturates at RAS_DEPTH.
//  - call and ret in the same cycle: ret wins (priority 3), no push.
//  - call without jump is ignored.
//  - exception does not modify the RAS. eret does not modify the EPC.
//  - Arithmetic is modulo 2^DATA_WIDTH. pc_plus_step wraps 32'hFFFF_FFFC -> 0 silently.
//    RAS pointer wraps mod RAS_DEPTH.
// STRUCTURE
//  - Shared package mips_pkg:
//    - constants DATA_WIDTH, RESET_VECTOR, EXC_VECTOR
//    - enum next_pc_sel_t {SEL_EXC, SEL_ERET, SEL_RET, SEL_JUMP, SEL_BRANCH, SEL_HOLD, SEL_SEQ}
//  - One sub-module, pc_ras: circular stack with push/pop/top/count ports and parameters
//    DATA_WIDTH and RAS_DEPTH.
//  - pc_unit contains the priority select, the PC register and the EPC register.
// TESTING
//  1 Reset then 3 idle clocks with RESET_VECTOR=0 -> pc_out 0,4,8,0xC.
//    Assert rst mid-count -> pc_out=0 immediately, before any clock edge.
//  2 pc=0x10, branch_taken, branch_target=0x40 -> redirect=1, next pc 0x40.
//    Same inputs with stall=1 -> pc stays 0x10 and redirect=0.
//  3 pc=0x20, jump+call, jump_target=0x100 -> pc 0x100, ras_count=1.
//    Then ret -> pc 0x24, ras_count=0.
//    Then ret with jump_target=0x300 -> pc 0x300, ras_count stays 0.
//  4 Push 5 calls with RAS_DEPTH=4 (return addresses A1..A5) -> ras_count=4.
//    4 rets yield A5,A4,A3,A2. A fifth ret falls back to jump_target.
//  5 pc=0x50, stall=1 with exception -> pc 0x8000_0180, epc_out=0x50.
//    Later eret -> pc 0x50. ras_count is unchanged throughout.
//  6 exception, ret, jump and branch_taken all in one cycle -> pc=EXC_VECTOR, RAS untouched.
//    call+ret in one cycle with count=2 -> pop only, count=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS fetch-stage definitions: default datapath constants and the
// next-PC source selector used by the program-counter unit.
package mips_pkg;

    localparam int          DATA_WIDTH   = 32;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR   = 32'h8000_0180;

    typedef enum logic [2:0] {
        SEL_EXC,
        SEL_ERET,
        SEL_RET,
        SEL_JUMP,
        SEL_BRANCH,
        SEL_HOLD,
        SEL_SEQ
    } next_pc_sel_t;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push into a full stack overwrites the
// oldest entry and the count saturates at RAS_DEPTH.
module pc_ras #(
    parameter int DATA_WIDTH = 32,
    parameter int RAS_DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic [DATA_WIDTH-1:0]          push_data,
    output logic [DATA_WIDTH-1:0]          top,
    output logic [$clog2(RAS_DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [CW-1:0]         count_q, count_d;

    // ptr_q always points at the next free slot, so the top sits one below it
    assign top   = mem_q[ptr_q - PW'(1)];
    assign count = count_q;

    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        if (pop) begin
            ptr_d = ptr_q - PW'(1);
            if (count_q != '0) begin
                count_d = count_q - CW'(1);
            end
        end else if (push) begin
            ptr_d = ptr_q + PW'(1);
            if (count_q != CW'(RAS_DEPTH)) begin
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !pop) begin
            mem_q[ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit for the fetch stage: priority next-PC select, PC and
// EPC registers, plus a return-address stack for call/return prediction.
module pc_unit #(
    parameter int                    DATA_WIDTH   = mips_pkg::DATA_WIDTH,
    parameter int                    PC_STEP      = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = DATA_WIDTH'(mips_pkg::RESET_VECTOR),
    parameter logic [DATA_WIDTH-1:0] EXC_VECTOR   = DATA_WIDTH'(mips_pkg::EXC_VECTOR),
    parameter int                    RAS_DEPTH    = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           stall,
    input  logic                           branch_taken,
    input  logic [DATA_WIDTH-1:0]          branch_target,
    input  logic                           jump,
    input  logic                           call,
    input  logic                           ret,
    input  logic [DATA_WIDTH-1:0]          jump_target,
    input  logic                           exception,
    input  logic                           eret,
    output logic [DATA_WIDTH-1:0]          pc_out,
    output logic [DATA_WIDTH-1:0]          pc_plus_step,
    output logic [DATA_WIDTH-1:0]          epc_out,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
    output logic                           redirect
);

    import mips_pkg::*;

    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] epc_q, epc_d;
    logic [DATA_WIDTH-1:0] ras_top;
    logic                  ras_push, ras_pop;
    next_pc_sel_t          sel;

    assign pc_out       = pc_q;
    assign epc_out      = epc_q;
    assign pc_plus_step = pc_q + DATA_WIDTH'(PC_STEP);

    // Exception is the only source that overrides a stall
    always_comb begin
        sel = SEL_SEQ;
        if (exception)         sel = SEL_EXC;
        else if (stall)        sel = SEL_HOLD;
        else if (eret)         sel = SEL_ERET;
        else if (ret)          sel = SEL_RET;
        else if (jump)         sel = SEL_JUMP;
        else if (branch_taken) sel = SEL_BRANCH;
    end

    always_comb begin
        pc_d     = pc_plus_step;
        epc_d    = epc_q;
        redirect = 1'b1;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        case (sel)
            SEL_EXC: begin
                pc_d  = EXC_VECTOR;
                epc_d = pc_q;
            end
            SEL_ERET:   pc_d = epc_q;
            SEL_RET: begin
                if (ras_count != '0) begin
                    pc_d    = ras_top;
                    ras_pop = 1'b1;
                end else begin
                    pc_d = jump_target;
                end
            end
            SEL_JUMP: begin
                pc_d     = jump_target;
                ras_push = call;
            end
            SEL_BRANCH: pc_d = branch_target;
            SEL_HOLD: begin
                pc_d     = pc_q;
                redirect = 1'b0;
            end
            default:    redirect = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= RESET_VECTOR;
            epc_q <= '0;
        end else begin
            pc_q  <= pc_d;
            epc_q <= epc_d;
        end
    end

    pc_ras #(
        .DATA_WIDTH (DATA_WIDTH),
        .RAS_DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus_step),
        .top       (ras_top),
        .count     (ras_count)
    );

endmodule
